// File: rtl/vout_dpi.sv
// DPI raster generator: hsync/vsync/de timing plus a one-word buffer that serialises 4-pixel Y8 words to 24-bit grey.
// Optional test pattern (h^v grey ramp, stream stalled) is built only when VOUT_DPI_TESTPAT_EN is defined.
module vout_dpi #(
  parameter int   H_ACTIVE = 1024,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 32,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 758,
  parameter int   V_FP     = 3,
  parameter int   V_SYNC   = 6,
  parameter int   V_BP     = 10,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_pixel,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        test_en,
  output logic        dpi_hsync,
  output logic        dpi_vsync,
  output logic        dpi_de,
  output logic [23:0] dpi_pixel,
  output logic        frame_start,
  output logic        underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic [31:0]   r_buf;
  logic          r_buf_valid;
  logic [1:0]    r_idx;

  logic [31:0]   w_h32;
  logic [31:0]   w_v32;
  logic          w_h_end;
  logic          w_v_end;
  logic          w_active;
  logic          w_line_end;
  logic          w_hsync_on;
  logic          w_vsync_on;
  logic          w_first_px;
  logic          w_tp;
  logic          w_accept;
  logic          w_underflow_evt;
  logic [7:0]    w_bytes [4];
  logic [7:0]    w_byte;
  logic [23:0]   w_pix_next;

  assign w_h32 = 32'(r_h_cnt);
  assign w_v32 = 32'(r_v_cnt);

  assign w_h_end    = (w_h32 == 32'(H_TOTAL - 1));
  assign w_v_end    = (w_v32 == 32'(V_TOTAL - 1));
  assign w_active   = (w_h32 < 32'(H_ACTIVE)) && (w_v32 < 32'(V_ACTIVE));
  assign w_line_end = w_active && (w_h32 == 32'(H_ACTIVE - 1));
  assign w_hsync_on = (w_h32 >= 32'(H_ACTIVE + H_FP)) && (w_h32 < 32'(H_ACTIVE + H_FP + H_SYNC));
  assign w_vsync_on = (w_v32 >= 32'(V_ACTIVE + V_FP)) && (w_v32 < 32'(V_ACTIVE + V_FP + V_SYNC));
  assign w_first_px = (w_h32 == 32'd0) && (w_v32 == 32'd0);

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign w_bytes[gi] = r_buf[8*gi +: 8];
  end
  assign w_byte = w_bytes[r_idx];

`ifdef VOUT_DPI_TESTPAT_EN
  logic [7:0] w_tp_y;
  assign w_tp   = test_en;
  assign w_tp_y = 8'(r_h_cnt) ^ 8'(r_v_cnt);
`else
  logic w_unused_test_en;
  assign w_tp             = 1'b0;
  assign w_unused_test_en = test_en;
`endif

  // Refill is allowed while the last byte of a word is being shown, so a
  // steady stream never leaves a gap at the word boundary.
  assign s_ready         = !rst && !w_tp && (!r_buf_valid || (w_active && r_idx == 2'd3));
  assign w_accept        = s_valid && s_ready;
  assign w_underflow_evt = w_active && !r_buf_valid && !w_tp;

  always_comb begin
    w_pix_next = 24'h000000;
`ifdef VOUT_DPI_TESTPAT_EN
    if (w_tp) begin
      if (w_active) w_pix_next = {3{w_tp_y}};
    end else if (w_active && r_buf_valid) begin
      w_pix_next = {3{w_byte}};
    end
`else
    if (w_active && r_buf_valid) w_pix_next = {3{w_byte}};
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_buf       <= '0;
      r_buf_valid <= 1'b0;
      r_idx       <= 2'd0;
      dpi_de      <= 1'b0;
      dpi_pixel   <= 24'h000000;
      dpi_hsync   <= ~HS_POL;
      dpi_vsync   <= ~VS_POL;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      r_h_cnt <= w_h_end ? '0 : r_h_cnt + 1'b1;
      if (w_h_end) r_v_cnt <= w_v_end ? '0 : r_v_cnt + 1'b1;

      dpi_de      <= w_active;
      dpi_pixel   <= w_pix_next;
      dpi_hsync   <= w_hsync_on ? HS_POL : ~HS_POL;
      dpi_vsync   <= w_vsync_on ? VS_POL : ~VS_POL;
      frame_start <= w_first_px;
      underflow   <= w_underflow_evt || (underflow && !w_first_px);

      if (w_tp) begin
        r_buf_valid <= 1'b0;
        r_idx       <= 2'd0;
      end else begin
        if (w_active && r_buf_valid) begin
          r_idx <= r_idx + 2'd1;
          if (r_idx == 2'd3) r_buf_valid <= 1'b0;
        end
        // Pixels left over from a partly used word never carry into the next line.
        if (w_line_end) begin
          r_idx       <= 2'd0;
          r_buf_valid <= 1'b0;
        end
        if (w_accept) begin
          r_buf       <= s_pixel;
          r_buf_valid <= 1'b1;
          r_idx       <= 2'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vout_dpi.sv
// Bench for vout_dpi: a pixel-queue reference model checked every cycle, plus literal expectations per scenario.
// Test-pattern checks are included when VOUT_DPI_TESTPAT_EN is defined.
module tb_vout_dpi;
  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
`ifdef VOUT_DPI_TESTPAT_EN
  localparam bit TP_BUILD = 1'b1;
`else
  localparam bit TP_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_pixel = 32'h03020100;
  logic        s_valid = 1'b0;
  logic        test_en = 1'b0;
  logic        s_ready;
  logic        dpi_hsync, dpi_vsync, dpi_de, frame_start, underflow;
  logic [23:0] dpi_pixel;

  always #5 clk = ~clk;

  vout_dpi #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .s_pixel(s_pixel), .s_valid(s_valid), .s_ready(s_ready),
    .test_en(test_en), .dpi_hsync(dpi_hsync), .dpi_vsync(dpi_vsync), .dpi_de(dpi_de),
    .dpi_pixel(dpi_pixel), .frame_start(frame_start), .underflow(underflow)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int m_t      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      if (n_fails <= 40)
        $display("FAIL %s: got %h expected %h (t=%0d, time %0t)", name, act, exp, m_t, $time);
    end
  endtask

  // Reference model: position from elapsed cycles, buffer as a queue of pending pixel bytes.
  logic [7:0]  mq[$];
  logic        e_de = 1'b0, e_hs = 1'b1, e_vs = 1'b1, e_fs = 1'b0, e_uf = 1'b0;
  logic [23:0] e_pix = 24'h0;
  int          acc_cnt = 0;
  bit          acc_flag = 1'b0;

  always @(negedge clk) begin
    int h, v;
    bit act, tp, rdy, uf_evt;
    logic [7:0] b;
    if (rst) begin
      mq.delete();
      m_t = 0;
      e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0; e_uf = 1'b0; e_pix = 24'h0;
      acc_flag = 1'b0;
      chk("rst_de", 32'(dpi_de), 32'(e_de));
      chk("rst_hsync", 32'(dpi_hsync), 32'(e_hs));
      chk("rst_vsync", 32'(dpi_vsync), 32'(e_vs));
      chk("rst_frame_start", 32'(frame_start), 32'(e_fs));
      chk("rst_underflow", 32'(underflow), 32'(e_uf));
      chk("rst_pixel", 32'(dpi_pixel), 32'(e_pix));
      chk("rst_s_ready", 32'(s_ready), 32'd0);
    end else begin
      chk("de", 32'(dpi_de), 32'(e_de));
      chk("hsync", 32'(dpi_hsync), 32'(e_hs));
      chk("vsync", 32'(dpi_vsync), 32'(e_vs));
      chk("frame_start", 32'(frame_start), 32'(e_fs));
      chk("underflow", 32'(underflow), 32'(e_uf));
      chk("pixel", 32'(dpi_pixel), 32'(e_pix));

      h   = m_t % HT;
      v   = (m_t / HT) % VT;
      act = (h < HA) && (v < VA);
      tp  = TP_BUILD && test_en;
      rdy = !tp && (mq.size() == 0 || (act && mq.size() == 1));
      chk("s_ready", 32'(s_ready), 32'(rdy));
      acc_flag = s_valid && s_ready;
      if (acc_flag) acc_cnt++;

      e_de  = act;
      e_hs  = (h >= HA + HF && h < HA + HF + HS) ? 1'b0 : 1'b1;
      e_vs  = (v >= VA + VF && v < VA + VF + VS) ? 1'b0 : 1'b1;
      e_fs  = (m_t % (HT * VT)) == 0;
      e_pix = 24'h0;
      uf_evt = 1'b0;
      if (tp) begin
        if (act) e_pix = {3{8'(h ^ v)}};
        mq.delete();
      end else begin
        if (act) begin
          if (mq.size() > 0) begin
            b = mq.pop_front();
            e_pix = {b, b, b};
          end else begin
            uf_evt = 1'b1;
          end
        end
        if (act && h == HA - 1) mq.delete();
        if (s_valid && rdy) begin
          mq.delete();
          for (int k = 0; k < 4; k++) mq.push_back(s_pixel[8*k +: 8]);
        end
      end
      e_uf = uf_evt ? 1'b1 : (e_fs ? 1'b0 : e_uf);
      m_t++;
    end
  end

  // Stimulus: cur_t is the raster position shown on the outputs after the last edge.
  int cur_t    = -1;
  bit seq_mode = 1'b1;
  bit seq_par  = 1'b1;

  function automatic logic [31:0] next_word();
    logic [31:0] w;
    if (seq_mode) begin
      w = seq_par ? 32'h07060504 : 32'h03020100;
      seq_par = !seq_par;
    end else begin
      w = $urandom;
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    cur_t++;
    #1;
    if (acc_flag) s_pixel = next_word();
  endtask

  task automatic goto(input int t);
    while (cur_t < t) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int snap;
    // Reset and idle timing
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hsync_lit", 32'(dpi_hsync), 32'd1);
    chk("reset_vsync_lit", 32'(dpi_vsync), 32'd1);
    chk("reset_de_lit", 32'(dpi_de), 32'd0);
    chk("reset_s_ready_lit", 32'(s_ready), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    cur_t = -1;
    goto(0);
    chk("fs_at_0", 32'(frame_start), 32'd1);
    chk("de_at_0", 32'(dpi_de), 32'd1);
    chk("uf_idle_0", 32'(underflow), 32'd1);
    goto(10); chk("hsync_at_10", 32'(dpi_hsync), 32'd0);
    goto(11); chk("hsync_at_11", 32'(dpi_hsync), 32'd0);
    goto(12); chk("hsync_at_12", 32'(dpi_hsync), 32'd1);
    // Continuous stream, first word enters during vertical blanking
    goto(59); s_valid = 1'b1;
    goto(69); chk("vsync_at_69", 32'(dpi_vsync), 32'd1);
    goto(70); chk("vsync_at_70", 32'(dpi_vsync), 32'd0);
    goto(83); chk("vsync_at_83", 32'(dpi_vsync), 32'd0);
    goto(84); chk("vsync_at_84", 32'(dpi_vsync), 32'd1);
    goto(97); chk("fs_at_97", 32'(frame_start), 32'd0);
    snap = acc_cnt;
    goto(98);
    chk("fs_at_98", 32'(frame_start), 32'd1);
    chk("uf_clear_98", 32'(underflow), 32'd0);
    chk("pix_98", 32'(dpi_pixel), 32'h000000);
    goto(99);  chk("pix_99", 32'(dpi_pixel), 32'h010101);
    goto(105); chk("pix_105", 32'(dpi_pixel), 32'h070707);
    goto(106); chk("de_106", 32'(dpi_de), 32'd0);
    goto(115); chk("pix_115", 32'(dpi_pixel), 32'h030303);
    goto(195);
    chk("words_frame1", 32'(acc_cnt - snap), 32'd8);
    chk("uf_frame1", 32'(underflow), 32'd0);
    // Line 1 of frame 2 starved
    goto(202); s_valid = 1'b0;
    goto(209); chk("uf_209", 32'(underflow), 32'd0);
    goto(210);
    chk("uf_210", 32'(underflow), 32'd1);
    chk("pix_210", 32'(dpi_pixel), 32'h000000);
    chk("de_210", 32'(dpi_de), 32'd1);
    goto(217); chk("pix_217", 32'(dpi_pixel), 32'h000000);
    s_valid = 1'b1;
    goto(224); chk("pix_224", 32'(dpi_pixel), 32'h000000);
    goto(225); chk("pix_225", 32'(dpi_pixel), 32'h010101);
    goto(231); chk("pix_231", 32'(dpi_pixel), 32'h070707);
    goto(293); chk("uf_293", 32'(underflow), 32'd1);
    goto(294);
    chk("uf_294", 32'(underflow), 32'd0);
    chk("fs_294", 32'(frame_start), 32'd1);
    // Empty buffer entering blanking with s_valid held high
    goto(342); s_valid = 1'b0;
    goto(343); s_valid = 1'b1;
    chk("pix_343", 32'(dpi_pixel), 32'h070707);
    snap = acc_cnt;
    goto(360); chk("s_ready_vblank", 32'(s_ready), 32'd0);
    goto(391); chk("words_blanking", 32'(acc_cnt - snap), 32'd1);
    goto(392);
    chk("fs_392", 32'(frame_start), 32'd1);
    chk("uf_392", 32'(underflow), 32'd0);
    goto(393); chk("pix_393", 32'(dpi_pixel), 32'h010101);
    // Asynchronous reset mid-line
    goto(425);
    chk("de_425", 32'(dpi_de), 32'd1);
    chk("pix_425", 32'(dpi_pixel), 32'h050505);
    #2 rst = 1'b1;
    s_valid = 1'b0;
    #1;
    chk("async_de", 32'(dpi_de), 32'd0);
    chk("async_pix", 32'(dpi_pixel), 32'h000000);
    chk("async_hsync", 32'(dpi_hsync), 32'd1);
    chk("async_s_ready", 32'(s_ready), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    cur_t = -1;
    goto(0);
    chk("fs_after_rst", 32'(frame_start), 32'd1);
    chk("de_after_rst", 32'(dpi_de), 32'd1);
    chk("uf_after_rst", 32'(underflow), 32'd1);
    // Randomised stream against the model
    seq_mode = 1'b0;
    for (int i = 0; i < 489; i++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      test_en = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 40) == 0) s_valid = 1'b0;
      tick();
    end
    test_en = 1'b0;
`ifdef VOUT_DPI_TESTPAT_EN
    test_en = 1'b1;
    s_valid = 1'b1;
    goto(490);
    chk("tp_pix_0_0", 32'(dpi_pixel), 32'h000000);
    chk("tp_de_0_0", 32'(dpi_de), 32'd1);
    goto(495); chk("tp_pix_5_0", 32'(dpi_pixel), 32'h050505);
    goto(507);
    chk("tp_pix_3_1", 32'(dpi_pixel), 32'h020202);
    chk("tp_s_ready", 32'(s_ready), 32'd0);
    goto(587);
    test_en = 1'b0;
`endif
    goto(600);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/vout_dpi.md
# vout_dpi

Board-level DPI video output. Generates DPI raster timing (hsync, vsync, data enable) from parameterised counters. Pulls 4-pixel Y8 words from an upstream valid/ready stream, the same packing that the video input path produces, and serialises them to one 24-bit grey pixel per clock. Sits between the framebuffer/processing pipeline and the parallel RGB panel or bridge pins, all in the pixel clock domain.

## Interface
Parameters:
- H_ACTIVE, 1024, active pixels per line; must be a multiple of 4
- H_FP, 16, horizontal front porch in clocks
- H_SYNC, 32, hsync width in clocks
- H_BP, 48, horizontal back porch in clocks
- V_ACTIVE, 758, active lines per frame
- V_FP, 3, vertical front porch in lines
- V_SYNC, 6, vsync width in lines
- V_BP, 10, vertical back porch in lines
- HS_POL, 1'b0, asserted level of dpi_hsync
- VS_POL, 1'b0, asserted level of dpi_vsync

Ports:
- clk  in  1  pixel clock; the only clock
- rst  in  1  asynchronous, active-high reset
- s_pixel  in  32  four Y8 pixels; pixel 0 is in [7:0], pixel 3 is in [31:24]
- s_valid  in  1  s_pixel valid
- s_ready  out  1  word accepted when s_valid && s_ready at a rising clk edge
- test_en  in  1  test-pattern select (see Configuration)
- dpi_hsync  out  1  horizontal sync
- dpi_vsync  out  1  vertical sync
- dpi_de  out  1  data enable
- dpi_pixel  out  24  {Y,Y,Y}
- frame_start  out  1  one-cycle pulse coincident with pixel (0,0)
- underflow  out  1  sticky: an active pixel was needed with no data buffered

## Operation
- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - v_cnt runs 0..V_TOTAL-1 and increments when h_cnt wraps.
  - Both wrap to 0.
- Region order on each axis: active, front porch, sync, back porch.
  - Sync on the horizontal axis is asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - The vertical axis uses the same rule, in lines.
- Active = h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- Holding buffer: one 32-bit word plus buf_valid flag and a 2-bit pixel index idx.
  - s_ready = !rst && (!buf_valid || (active && idx==3 && buf_valid)). This is combinational and allows a back-to-back refill at the word boundary.
- Each active cycle:
  - If buf_valid: output byte idx, increment idx; at idx==3, clear buf_valid unless a new word is accepted in the same cycle.
  - If !buf_valid: output 24'h000000, set underflow, do not advance idx.
- At the end of each active line (h_cnt==H_ACTIVE-1), idx is forced to 0.
  - A partially consumed word is discarded (buf_valid cleared) unless a new word is accepted that cycle.
- During blanking at most one word is accepted, which fills the buffer. No further words are accepted until active pixels drain it.
- underflow clears on the cycle frame_start asserts, unless an underflow occurs in that same cycle (set wins).

## Timing
- Reset values: h_cnt=0, v_cnt=0, buf_valid=0, idx=0, dpi_de=0, dpi_pixel=0, dpi_hsync=~HS_POL, dpi_vsync=~VS_POL, frame_start=0, underflow=0, s_ready=0.
- All dpi_* outputs, frame_start and underflow are registered. Each is driven one clock after the counter state it decodes, so they are mutually aligned.
- The first edge after rst deasserts samples h_cnt=v_cnt=0. frame_start and dpi_de for pixel (0,0) appear after that edge.
- Data latency: a word accepted at edge N can supply its pixel 0 to dpi_pixel at edge N+1 at the earliest.
- Frame period is exactly H_TOTAL*V_TOTAL clocks, independent of s_valid.
- Reset asserted mid-line: all state returns to reset values immediately. Any buffered word is dropped.

## Configuration
- VOUT_DPI_TESTPAT_EN defined, and test_en=1:
  - dpi_pixel = {3{h_cnt[7:0] ^ v_cnt[7:0]}} during active, else 0.
  - s_ready is held 0 and the buffer is flushed.
  - underflow does not set.
  - Sync timing is unchanged.
- VOUT_DPI_TESTPAT_EN not defined: test_en is ignored and no pattern logic is synthesised.

## Test plan
Parameters for all scenarios: H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 (H_TOTAL=14, V_TOTAL=7).

1. Reset, then idle with s_valid=0:
   - dpi_hsync low for 2 of every 14 clocks, at output positions 10–11.
   - dpi_vsync low for line 5.
   - frame_start every 98 clocks.
   - All outputs at reset values while rst=1.
2. Continuous s_valid with words 0x03020100, then 0x07060504, repeating:
   - Each active line outputs 0x000000, 0x010101, … 0x070707.
   - Exactly 2 words accepted per line, 8 per frame.
   - underflow stays 0.
3. s_valid=0 for all of line 1 only:
   - Line 1 outputs 0x000000 for 8 de cycles.
   - underflow=1 from the first missing pixel until the next frame_start.
   - Line 2 outputs correct data from pixel 0.
4. s_valid held 1 throughout blanking: exactly one word accepted during blanking, then s_ready=0 until the first active line drains it.
5. rst pulsed at h_cnt=5 of line 2: outputs return to reset values asynchronously. After release, a new frame starts at (0,0) with idx=0.
6. Macro defined, test_en=1: line 1, pixel 3 outputs 0x020202; s_ready=0 throughout.
